// File: rtl/boa_mem_arbiter_pkg.sv
// Shared types for the boa memory arbiter: owner encoding, request bundle
// and a helper that decides whether a bus is presenting a request.
package boa_mem_arbiter_pkg;

   // Width of the starvation counter; limits above 15 cannot be represented.
   localparam int unsigned STARVE_W = 4;

   typedef enum logic [1:0] {
      ARB_NONE = 2'd0,
      ARB_PBUS = 2'd1,
      ARB_DBUS = 2'd2
   } boa_arb_owner_t;

   // Request side of one bus, gathered so the winner can be muxed as a unit.
   typedef struct packed {
      logic        re;
      logic [3:0]  we;
      logic [31:2] addr;
      logic [31:0] wdata;
   } boa_mem_req_t;

   // A read and a write are treated identically: either one is a request.
   function automatic logic req_active(input boa_mem_req_t r);
      return r.re | (|r.we);
   endfunction

endpackage : boa_mem_arbiter_pkg

// File: rtl/boa_mem_arbiter_if.sv
// Word-addressed memory bus between a CPU-side requester and a memory.
// MEM is the view of whoever serves requests; CPU is the view of whoever issues them.
interface boa_mem_bus;

   logic        re;
   logic [3:0]  we;
   logic [31:2] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;

   modport MEM (
      input  re,
      input  we,
      input  addr,
      input  wdata,
      output rdata,
      output ready
   );

   modport CPU (
      output re,
      output we,
      output addr,
      output wdata,
      input  rdata,
      input  ready
   );

endinterface : boa_mem_bus

// File: rtl/boa_mem_arbiter.sv
// Shares a single memory port between the fetch bus (pbus) and the data bus
// (dbus). Arbitration and routing are combinational, so a grant reaches the
// memory in the same cycle the request appears. An owner register remembers
// who issued the outstanding access so only that bus receives ready.
module boa_mem_arbiter
   import boa_mem_arbiter_pkg::*;
#(
   parameter int unsigned starve_limit  = 4,     // 1..15 consecutive preferred grants
   parameter bit          data_priority = 1'b1   // 1: dbus wins ties, 0: pbus wins ties
) (
   input  logic        clk,
   input  logic        rst,
   boa_mem_bus.MEM     pbus,
   boa_mem_bus.MEM     dbus,
   boa_mem_bus.CPU     mbus,
   output logic [1:0]  owner
);

   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(starve_limit);

   // Which bus wins ties, and which one the starvation counter protects.
   localparam boa_arb_owner_t PREF_BUS  = data_priority ? ARB_DBUS : ARB_PBUS;
   localparam boa_arb_owner_t OTHER_BUS = data_priority ? ARB_PBUS : ARB_DBUS;

   boa_arb_owner_t       owner_q, owner_d;
   logic [STARVE_W-1:0]  starve_cnt_q, starve_cnt_d;

   boa_mem_req_t         p_req_s, d_req_s, sel_req_s;
   boa_arb_owner_t       winner;
   boa_arb_owner_t       sel_bus;
   logic                 p_req, d_req;
   logic                 pref_req, other_req;
   logic                 slot_open;
   logic                 starved;

   // Bundle each bus's request fields for muxing.
   always_comb begin
      p_req_s = '{re: pbus.re, we: pbus.we, addr: pbus.addr, wdata: pbus.wdata};
      d_req_s = '{re: dbus.re, we: dbus.we, addr: dbus.addr, wdata: dbus.wdata};
   end

   // Owner and starvation counter registers; control state is cleared by a synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: state flops use non-blocking assignments so every flop samples
      // its _d value from before this edge, regardless of statement order.
      if (rst) begin
         owner_q      <= ARB_NONE;
         starve_cnt_q <= '0;
      end else begin
         owner_q      <= owner_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // Arbitration: pick the winner of an open issue slot and compute next state.
   always_comb begin
      // NOTE: every output of this block gets a default first; a path that
      // left one unassigned would infer a latch.
      winner       = ARB_NONE;
      owner_d      = owner_q;
      starve_cnt_d = starve_cnt_q;

      p_req     = req_active(p_req_s);
      d_req     = req_active(d_req_s);
      pref_req  = data_priority ? d_req : p_req;
      other_req = data_priority ? p_req : d_req;

      // A slot opens when nothing is outstanding or the outstanding access completes.
      slot_open = (owner_q == ARB_NONE) || mbus.ready;
      starved   = (starve_cnt_q == STARVE_MAX);

      if (!rst && slot_open) begin
         if (pref_req && other_req) begin
            winner = starved ? OTHER_BUS : PREF_BUS;
         end else if (pref_req) begin
            winner = PREF_BUS;
         end else if (other_req) begin
            winner = OTHER_BUS;
         end
         // An open slot with no requester leaves the port idle.
         owner_d = winner;
      end

      // The counter only matters while the non-preferred bus is waiting.
      if (!other_req) begin
         starve_cnt_d = '0;
      end else if (winner == PREF_BUS) begin
         if (starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
         end
      end else if (winner == OTHER_BUS) begin
         starve_cnt_d = '0;
      end
   end

   // Memory-side mux: the winner drives the port in an open slot, otherwise
   // the command is idle and address/data follow the current owner.
   always_comb begin
      sel_bus   = (winner != ARB_NONE) ? winner : owner_q;
      sel_req_s = (sel_bus == ARB_DBUS) ? d_req_s : p_req_s;

      mbus.re    = (winner != ARB_NONE) ? sel_req_s.re : 1'b0;
      mbus.we    = (winner != ARB_NONE) ? sel_req_s.we : 4'b0000;
      mbus.addr  = sel_req_s.addr;
      mbus.wdata = sel_req_s.wdata;
   end

   // Response routing: ready goes only to the owner; rdata is broadcast.
   always_comb begin
      pbus.ready = !rst && mbus.ready && (owner_q == ARB_PBUS);
      dbus.ready = !rst && mbus.ready && (owner_q == ARB_DBUS);
      pbus.rdata = mbus.rdata;
      dbus.rdata = mbus.rdata;
   end

   assign owner = owner_q;

endmodule : boa_mem_arbiter
